// File: rtl/mantissa_align_add_if.sv
// mantissa_align_add_if: operand/result handshake bundle for the mantissa aligner-adder
interface mantissa_align_add_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exponent;
  logic [24:0] mantissa;
  logic        carry;
  logic        zero;
  modport master (output a, b, in_valid, out_ready,
                  input  in_ready, out_valid, sign, exponent, mantissa, carry, zero);
  modport slave  (input  a, b, in_valid, out_ready,
                  output in_ready, out_valid, sign, exponent, mantissa, carry, zero);
endinterface

// File: rtl/mantissa_align_add.sv
// mantissa_align_add: aligns two single-precision significands one bit per cycle and adds/subtracts them
module mantissa_align_add #(
  parameter int MAX_SHIFT = 25
) (
  input logic clk,
  input logic rst_n,
  mantissa_align_add_if.slave io
);
  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;
  localparam logic [8:0] MS = 9'(MAX_SHIFT);
  state_t      state;
  logic        sub_q;
  logic        sign_l;
  logic [7:0]  exp_l;
  logic [23:0] sig_l;
  logic [23:0] sig_s;
  logic [7:0]  cnt;
  logic        a_big;
  logic [31:0] l_op;
  logic [31:0] s_op;
  logic [7:0]  diff;
  logic [24:0] sum;
  // a wins ties so equal magnitudes keep a's sign
  assign a_big = io.a[30:0] >= io.b[30:0];
  assign l_op  = a_big ? io.a : io.b;
  assign s_op  = a_big ? io.b : io.a;
  assign diff  = l_op[30:23] - s_op[30:23];
  assign sum   = sub_q ? {1'b0, sig_l} - {1'b0, sig_s} : {1'b0, sig_l} + {1'b0, sig_s};
  // accept -> shift smaller significand until aligned -> hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.sign      <= 1'b0;
      io.exponent  <= '0;
      io.mantissa  <= '0;
      io.carry     <= 1'b0;
      io.zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          sub_q       <= io.a[31] ^ io.b[31];
          sign_l      <= l_op[31];
          exp_l       <= l_op[30:23];
          sig_l       <= {|l_op[30:23], l_op[22:0]};
          sig_s       <= ({1'b0, diff} >= MS) ? 24'd0 : {|s_op[30:23], s_op[22:0]};
          cnt         <= ({1'b0, diff} >= MS) ? 8'd0 : diff;
          io.in_ready <= 1'b0;
          state       <= ALIGN;
        end
        ALIGN: if (cnt != 8'd0) begin
          sig_s <= sig_s >> 1;
          cnt   <= cnt - 8'd1;
        end else begin
          io.mantissa  <= sum;
          io.carry     <= sum[24];
          io.zero      <= sum == 25'd0;
          io.sign      <= (sum == 25'd0) ? 1'b0 : sign_l;
          io.exponent  <= (sum == 25'd0) ? 8'd0 : exp_l;
          io.out_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: if (io.out_ready) begin
          io.out_valid <= 1'b0;
          io.in_ready  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mantissa_align_add.sv
// tb_mantissa_align_add: directed scoreboard bench for the mantissa aligner-adder
module tb_mantissa_align_add;
  localparam int MS = 25;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [24:0] mantissa;
    logic        zero;
    logic [8:0]  lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  exp_t sbq[$];
  mantissa_align_add_if io ();
  mantissa_align_add #(.MAX_SHIFT(MS)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [31:0] l, s;
    logic [23:0] sl, ss;
    logic [24:0] r;
    int d;
    if (y[30:0] > x[30:0]) begin l = y; s = x; end else begin l = x; s = y; end
    sl = {l[30:23] != 0, l[22:0]};
    ss = {s[30:23] != 0, s[22:0]};
    d = int'(l[30:23]) - int'(s[30:23]);
    if (d >= MS) begin ss = 0; e.lat = 9'd1; end
    else begin ss = ss >> d; e.lat = 9'(d + 1); end
    r = (x[31] == y[31]) ? {1'b0, sl} + {1'b0, ss} : {1'b0, sl} - {1'b0, ss};
    e.mantissa = r;
    e.zero = (r == 0);
    e.sign = (r == 0) ? 1'b0 : l[31];
    e.exponent = (r == 0) ? 8'd0 : l[30:23];
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
    chk({tag, "_fields"}, {io.sign, io.exponent, io.carry, io.zero}, 32'd0);
    chk({tag, "_mantissa"}, 32'(io.mantissa), 32'd0);
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_sign"}, 32'(io.sign), 32'(e.sign));
    chk({tag, "_exp"}, 32'(io.exponent), 32'(e.exponent));
    chk({tag, "_mant"}, 32'(io.mantissa), 32'(e.mantissa));
    chk({tag, "_carry"}, 32'(io.carry), 32'(e.mantissa[24]));
    chk({tag, "_zero"}, 32'(io.zero), 32'(e.zero));
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input int hold);
    exp_t e;
    int n;
    @(negedge clk);
    io.a = x; io.b = y; io.in_valid = 1'b1; io.out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(io.in_ready), 32'd1);
    sbq.push_back(model(x, y));
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk({tag, "_busy_ready"}, 32'(io.in_ready), 32'd0);
    n = 0;
    while (!io.out_valid && n < 60) begin @(posedge clk); #1; n++; end
    e = sbq.pop_front();
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk_out(tag, e);
    for (int i = 0; i < hold; i++) begin
      io.in_valid = i[0] ? 1'b0 : 1'b1; io.a = ~x; io.b = x;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(io.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(io.in_ready), 32'd0);
      chk_out({tag, "_hold"}, e);
    end
    io.out_ready = 1'b1; io.in_valid = 1'b1; io.a = 32'h40000000; io.b = 32'h40000000;
    @(posedge clk); #1;
    chk({tag, "_taken_valid"}, 32'(io.out_valid), 32'd0);
    chk({tag, "_taken_ready"}, 32'(io.in_ready), 32'd1);
    io.out_ready = 1'b0; io.in_valid = 1'b0;
  endtask

  initial begin
    io.a = '0; io.b = '0; io.in_valid = 1'b0; io.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    rst_n = 1'b1;
    op("one_plus_one", 32'h3F800000, 32'h3F800000, 0);
    op("d1", 32'h3F800000, 32'h3F000000, 0);
    op("d2_neg", 32'hC0000000, 32'h3F000000, 0);
    op("cancel", 32'h3F800000, 32'hBF800000, 0);
    op("d25_sat", 32'h4C000000, 32'h3F800000, 0);
    op("d24_edge", 32'h4B800000, 32'h3FFFFFFF, 0);
    op("swap_b", 32'h3F000000, 32'hC0000000, 0);
    op("tie_sign", 32'hBF800001, 32'h3F800001, 0);
    op("denorm", 32'h00000003, 32'h00000001, 0);
    op("hold3", 32'h40400000, 32'h3FC00000, 3);
    for (int i = 0; i < 4; i++)
      op("rand", $urandom & 32'hBFFFFFFF, ($urandom & 32'h3F7FFFFF) | (32'(i[0]) << 31), 1);
    @(negedge clk);
    io.a = 32'h4B000000; io.b = 32'h3F800000; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset("abort");
    rst_n = 1'b1;
    op("after_abort", 32'h3F800000, 32'h3F000000, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mantissa_align_add.md
MANTISSA_ALIGN_ADD -- requirements
Module: mantissa_align_add

Interface
REQ-001 The block SHALL have parameter MAX_SHIFT, default 25: when the exponent difference is at or above this value, the smaller mantissa SHALL be zeroed without shifting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port a, input, 32 bits: IEEE-754 single operand A.
REQ-005 The block SHALL have port b, input, 32 bits: IEEE-754 single operand B.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result ports are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream normalizer accepts the result.
REQ-010 The block SHALL have port sign, output, 1 bit: sign of the result.
REQ-011 The block SHALL have port exponent, output, 8 bits: biased exponent of the larger-magnitude operand.
REQ-012 The block SHALL have port mantissa, output, 25 bits: raw sum or difference, with bit 24 as overflow.
REQ-013 The block SHALL have port carry, output, 1 bit: equal to mantissa[24].
REQ-014 The block SHALL have port zero, output, 1 bit: result is exactly zero; downstream SHALL NOT normalize when zero is high.

Function
REQ-015 The FSM SHALL have states IDLE, ALIGN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept: on an edge in IDLE with in_valid=1, the block SHALL capture the operands and enter ALIGN.
REQ-017 Hidden bit SHALL be (exp!=0); each significand SHALL be {hidden, frac[22:0]}, 24 bits.
REQ-018 Swap rule: the operand with the larger {exp,frac} SHALL be L and the other S; on a tie, a SHALL be L.
REQ-019 Shift count SHALL be d = expL-expS; if d>=MAX_SHIFT, S significand SHALL be loaded as 0 and the count as 0.
REQ-020 In ALIGN, each edge with count!=0 SHALL shift the S significand right by 1 and decrement count, one bit per cycle.
REQ-021 In ALIGN, an edge with count==0 SHALL register the result, set out_valid=1 and enter DONE.
REQ-022 The result SHALL be L+S (25-bit) if signs are equal, else L-S.
REQ-023 Result fields: sign=signL, exponent=expL, carry=mantissa[24].
REQ-024 Latency from the accept edge to out_valid high SHALL be min(d, MAX_SHIFT-1 saturated to 0 when d>=MAX_SHIFT)+1 edges, i.e. d+1 for d<MAX_SHIFT and 1 otherwise.
REQ-025 Zero result (mantissa==0): zero=1, exponent=0, sign=0 (+0.0).
REQ-026 In DONE, all outputs SHALL hold stable while out_ready=0.
REQ-027 An edge with out_valid=1 and out_ready=1 SHALL clear out_valid and return to IDLE; new operands SHALL NOT be accepted on that same edge.
REQ-028 in_valid SHALL be ignored outside IDLE; no input is buffered.
REQ-029 NaN and Inf operands are out of scope; outputs for them are don't-care, but the FSM SHALL still complete and return to IDLE.

Reset
REQ-030 While rst_n=0 at an edge: state=IDLE, in_ready=1, out_valid=0, sign=0, exponent=0, mantissa=0, carry=0, zero=0.
REQ-031 Reset asserted in ALIGN or DONE SHALL abort the operation with no output handshake, and reach the REQ-030 values at that edge.

Verification
REQ-032 Scenario: a=0x3F800000, b=0x3F800000 -> out_valid 1 edge after accept; carry=1, mantissa=0x1000000, exponent=0x7F, sign=0, zero=0.
REQ-033 Scenario: a=0x3F800000, b=0x3F000000 (d=1) -> out_valid 2 edges after accept; mantissa=0x0C00000, carry=0, exponent=0x7F.
REQ-034 Scenario: a=0xC0000000, b=0x3F000000 (d=2) -> out_valid 3 edges after accept; mantissa=0x0600000, sign=1, exponent=0x80.
REQ-035 Scenario: a=0x3F800000, b=0xBF800000 -> zero=1, mantissa=0, exponent=0, sign=0.
REQ-036 Scenario: a=0x4C000000, b=0x3F800000 (d=25) -> out_valid 1 edge after accept; mantissa=0x0800000, exponent=0x98.
REQ-037 Scenario: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, nothing accepted; then assert rst_n=0 during a later ALIGN -> IDLE with REQ-030 values at the next edge.
